// File: rtl/pixel_writer_pkg.sv
// Shared constants and state encoding for the on-chip pixel writer.
// Sized for the 16K x 32 single-port RAM it feeds.
package pixel_writer_pkg;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16384;
    localparam int CNT_W  = 17;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        FLUSH,
        FIN
    } state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// Packs 8-bit pixels into little-endian 32-bit words.
// Emits a word on the cycle its last lane, or the job's last pixel, is accepted.
module byte_lane_packer
    import pixel_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic        last,
    input  logic [7:0]  pix,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        word_valid
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] pack_q, pack_d;
    logic [3:0]  be_q, be_d;

    always_comb begin
        word       = pack_q | ({24'd0, pix} << {lane_q, 3'b000});
        be         = be_q | (4'b0001 << lane_q);
        word_valid = accept && (lane_q == 2'(LANES - 1) || last);
        lane_d     = lane_q;
        pack_d     = pack_q;
        be_d       = be_q;
        // Emptied lanes stay zero, so a short tail word reads back as zero-padded
        if (clear || word_valid) begin
            lane_d = '0;
            pack_d = '0;
            be_d   = '0;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
            pack_d = word;
            be_d   = be;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q <= '0;
            pack_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
            be_q   <= be_d;
        end
    end

endmodule

// File: rtl/onchip_pixel_writer.sv
// Streams 8-bit pixels into a contiguous region of the on-chip RAM.
// Owns the job FSM, range check, address counter and write register.
module onchip_pixel_writer #(
    parameter int ADDR_W = pixel_writer_pkg::ADDR_W,
    parameter int DEPTH  = pixel_writer_pkg::DEPTH,
    parameter int CNT_W  = pixel_writer_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_pixels,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              err_range
);
    import pixel_writer_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [3:0]        wr_be_q, wr_be_d;
    logic              wr_valid_q, wr_valid_d;
    logic              err_q, err_d;
    logic              clken_q;

    logic [CNT_W:0]    words;
    logic [CNT_W+1:0]  span;
    logic              range_bad;
    logic              req;
    logic              accept;
    logic              last;
    logic              wr_en;
    logic [31:0]       word;
    logic [3:0]        be;
    logic              word_valid;

    assign words     = ({1'b0, num_pixels} + (CNT_W + 1)'(3)) >> 2;
    assign span      = (CNT_W + 2)'(base_addr) + (CNT_W + 2)'(words);
    assign range_bad = span > (CNT_W + 2)'(DEPTH);
    assign req       = (state_q == IDLE) && start && !abort;
    assign accept    = pix_ready && pix_valid;
    assign last      = left_q == CNT_W'(1);

    byte_lane_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      ((state_q != PACK) || abort),
        .accept     (accept),
        .last       (last),
        .pix        (pix_data),
        .word       (word),
        .be         (be),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && !range_bad) begin
                    state_d = (num_pixels == '0) ? FIN : PACK;
                end
            end
            PACK: begin
                if (accept && last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        pix_ready = (state_q == PACK) && !abort;
        busy      = state_q != IDLE;
        done      = state_q == FIN;
    end

    always_comb begin
        addr_d     = addr_q;
        left_d     = left_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        wr_valid_d = word_valid;
        err_d      = req && range_bad;
        if (req) begin
            addr_d = base_addr;
            left_d = num_pixels;
        end
        if (accept) begin
            left_d = left_q - CNT_W'(1);
        end
        if (word_valid) begin
            wr_addr_d = addr_q;
            wr_data_d = word;
            wr_be_d   = be;
            addr_d    = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= '0;
            left_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            left_q     <= left_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
            clken_q    <= 1'b1;
        end
    end

    // A pending write is killed in the same cycle as a cancel or reset
    assign wr_en          = wr_valid_q && !abort && reset_n;
    assign mem_write      = wr_en;
    assign mem_chipselect = wr_en;
    assign mem_address    = wr_en ? wr_addr_q : '0;
    assign mem_writedata  = wr_en ? wr_data_q : '0;
    assign mem_byteenable = wr_en ? wr_be_q : '0;
    assign mem_clken      = clken_q;
    assign err_range      = err_q;

endmodule

// File: tb/tb_onchip_pixel_writer.sv
// Directed bench for onchip_pixel_writer with a queue-based write model.
// Every RAM write is compared against words derived from the pixel list.
module tb_onchip_pixel_writer;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [13:0] base_addr;
    logic [16:0] num_pixels;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        err_range;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   mon_on = 1'b0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    logic [7:0] pix_arr [0:15];

    onchip_pixel_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .num_pixels     (num_pixels),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .err_range      (err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every RAM write against the model queue
    always @(negedge clk) begin
        wr_t o;
        wr_t e;
        if (mon_on) begin
            if (done) done_cnt++;
            chk("cs_eq_write", mem_chipselect, mem_write);
            if (mem_write) begin
                o.addr = mem_address;
                o.data = mem_writedata;
                o.be   = mem_byteenable;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", mem_address, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", o.addr, e.addr);
                    chk("wr_data", o.data, e.data);
                    chk("wr_be", o.be, e.be);
                end
            end
        end
    end

    // stop_k < 0: run to completion; else cancel after stop_k accepted pixels
    task automatic run_job(input logic [13:0] base, input int n, input bit gap,
                           input int ov_k, input int stop_k, input bit by_reset);
        int wn;
        int lim;
        int d0;
        wr_t e;
        obs_q.delete();
        wn = (stop_k < 0) ? (n + 3) / 4 : (stop_k - 1) / 4;
        for (int w = 0; w < wn; w++) begin
            e.addr = base + 14'(w);
            e.data = '0;
            e.be   = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.data[8*b +: 8] = pix_arr[4*w+b];
                    e.be[b] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        lim = (stop_k < 0) ? n : stop_k;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        num_pixels = 17'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("zero_done_s1", done, 1'b1);
            chk("zero_ready_s1", pix_ready, 1'b0);
            @(negedge clk);
            chk("zero_busy_s2", busy, 1'b0);
        end else begin
            pix_valid = 1'b1;
            pix_data = pix_arr[0];
            @(negedge clk);
            chk("busy_s1", busy, 1'b1);
            chk("ready_s1", pix_ready, 1'b1);
            for (int k = 0; k < lim; k++) begin
                if (k > 0) begin
                    if (gap) begin
                        pix_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    pix_valid = 1'b1;
                    pix_data = pix_arr[k];
                    if (k == ov_k) begin
                        start = 1'b1;
                        base_addr = 14'h3000;
                        num_pixels = 17'd4;
                    end
                    @(negedge clk);
                    chk("ready_pack", pix_ready, 1'b1);
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            pix_valid = 1'b0;
            if (stop_k < 0) begin
                @(negedge clk);
                chk("last_write_l1", mem_write, 1'b1);
                chk("no_done_l1", done, 1'b0);
                @(negedge clk);
                chk("done_l2", done, 1'b1);
                chk("busy_l2", busy, 1'b1);
                chk("no_write_l2", mem_write, 1'b0);
                @(negedge clk);
                chk("busy_l3", busy, 1'b0);
                chk("done_l3", done, 1'b0);
            end else if (!by_reset) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 1'b0);
                chk("abort_ready", pix_ready, 1'b0);
            end else begin
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(negedge clk);
                chk("rst_ready", pix_ready, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_err", err_range, 1'b0);
                chk("rst_clken", mem_clken, 1'b0);
                chk("rst_mem", {mem_address, mem_byteenable, mem_chipselect, mem_write}, 32'd0);
                chk("rst_wdata", mem_writedata, 32'd0);
            end
        end
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), (stop_k < 0) ? 32'd1 : 32'd0);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        num_pixels = '0;
        pix_data = '0;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", pix_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err_range, 1'b0);
        chk("reset_clken", mem_clken, 1'b0);
        chk("reset_mem", {mem_address, mem_byteenable, mem_chipselect, mem_write}, 32'd0);
        mon_on = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("clken_after_reset", mem_clken, 1'b1);

        // 16380 + 5 words overruns the RAM
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 14'd16380;
        num_pixels = 17'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("range_err_s1", err_range, 1'b1);
        chk("range_busy_s1", busy, 1'b0);
        chk("range_ready_s1", pix_ready, 1'b0);
        @(negedge clk);
        chk("range_err_s2", err_range, 1'b0);
        chk("range_busy_s2", busy, 1'b0);
        repeat (3) @(negedge clk);

        // 13 pixels = 4 words ending exactly at the top of RAM
        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(8'h10 + i);
        run_job(14'd16380, 13, 1'b0, -1, -1, 1'b0);
        chk("top_word_addr", obs_q[3].addr, 14'd16383);
        chk("top_word_data", obs_q[3].data, 32'h0000_001C);
        chk("top_word_be", obs_q[3].be, 4'h1);

        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(i + 1);
        run_job(14'h100, 8, 1'b0, -1, -1, 1'b0);
        chk("full_n", 32'(obs_q.size()), 32'd2);
        chk("full_w0_addr", obs_q[0].addr, 14'h100);
        chk("full_w0_data", obs_q[0].data, 32'h0403_0201);
        chk("full_w0_be", obs_q[0].be, 4'hF);
        chk("full_w1_addr", obs_q[1].addr, 14'h101);
        chk("full_w1_data", obs_q[1].data, 32'h0807_0605);

        // start pulsed at pixel 2 must not disturb the running job
        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(8'hA0 + i);
        run_job(14'h0, 6, 1'b0, 2, -1, 1'b0);
        chk("tail_n", 32'(obs_q.size()), 32'd2);
        chk("tail_addr", obs_q[1].addr, 14'd1);
        chk("tail_data", obs_q[1].data, 32'h0000_A5A4);
        chk("tail_be", obs_q[1].be, 4'h3);

        run_job(14'h50, 0, 1'b0, -1, -1, 1'b0);
        chk("zero_writes", 32'(obs_q.size()), 32'd0);

        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(8'h30 + i);
        run_job(14'h40, 12, 1'b1, -1, 7, 1'b0);
        chk("abort_n", 32'(obs_q.size()), 32'd1);
        chk("abort_w0", obs_q[0].data, 32'h3332_3130);

        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(8'h70 + i);
        run_job(14'h200, 8, 1'b0, -1, 2, 1'b1);
        chk("rst_writes", 32'(obs_q.size()), 32'd0);
        @(negedge clk);
        chk("clken_after_midreset", mem_clken, 1'b1);

        for (int i = 0; i < 16; i++) pix_arr[i] = 8'(8'hC0 + i);
        run_job(14'h200, 4, 1'b0, -1, -1, 1'b0);
        chk("post_rst_addr", obs_q[0].addr, 14'h200);
        chk("post_rst_data", obs_q[0].data, 32'hC3C2_C1C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_pixel_writer.md
# onchip_pixel_writer

Streaming pixel-to-memory stage that sits directly upstream of the 16K x 32 single-port on-chip RAM. Accepts 8-bit grayscale pixels on a valid/ready stream, packs four pixels per 32-bit word (little-endian byte lanes), and writes the packed words into a contiguous RAM region through the RAM's slave port. This lets each processing core's image tile be loaded without CPU-driven copies.

## Interface
- `ADDR_W`, 14, RAM word-address width.
- `DEPTH`, 16384, RAM depth in words.
- `CNT_W`, 17, pixel-count width; must hold `DEPTH*4`.

Ports:
- `clk` in 1: single clock, shared with the RAM.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `abort` in 1: synchronous job cancel.
- `base_addr` in `ADDR_W`: first word address; sampled with `start`.
- `num_pixels` in `CNT_W`: pixel count; sampled with `start`.
- `pix_data` in 8: pixel value.
- `pix_valid` in 1: pixel present.
- `pix_ready` out 1: block accepts a pixel this cycle.
- `mem_address` out `ADDR_W`: RAM word address.
- `mem_byteenable` out 4: RAM byte lanes.
- `mem_chipselect` out 1: RAM select.
- `mem_write` out 1: RAM write strobe.
- `mem_writedata` out 32: RAM write data.
- `mem_clken` out 1: RAM clock enable; constant 1 after reset.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `err_range` out 1: one-cycle pulse when a job is rejected.

## Operation
- FSM states: IDLE, PACK, FLUSH, FIN.
- **IDLE.** On `start`:
  - Compute `words = ceil(num_pixels/4)`.
  - If `base_addr + words > DEPTH`, pulse `err_range` next cycle and stay in IDLE. No wrap-around writes, ever.
  - Else if `num_pixels == 0`, go to FIN.
  - Else latch the address and count, and go to PACK.
- **PACK.**
  - `pix_ready = 1`. The RAM has no waitrequest, so there is no backpressure.
  - A pixel is accepted when `pix_valid & pix_ready`.
  - Pixel k goes to byte lane `k mod 4`, in bits `[8*(k mod 4)+7 : 8*(k mod 4)]`.
  - When lane 3 fills, or the final pixel is accepted, the word moves to the write register. The write register is separate from the pack register, so acceptance continues at 1 pixel/cycle.
  - Unfilled lanes of a final partial word are zero, and their byteenable bits are 0.
  - After the final pixel, go to FLUSH.
- **FLUSH.** The last pending write issues. Go to FIN.
- **FIN.** `done = 1` for one cycle. Return to IDLE.
- **Write port.**
  - `mem_chipselect` and `mem_write` are high together for exactly one cycle per word. They are low otherwise.
  - Addresses increase by 1 from `base_addr`.
- **`busy`.** High in PACK, FLUSH and FIN.
- **`start` while busy.** Ignored.
- **`abort`, or `reset_n` low, mid-job.**
  - Go to IDLE at the next edge.
  - Drop the partial word, with no write for it.
  - No `done`.
  - A write already in the write register in that same cycle is suppressed.
- **`abort` and `start` in the same cycle.** `abort` wins.

## Timing
- **Reset values:** `pix_ready = 0`, `mem_* = 0` (`mem_clken = 0` only during reset, 1 after), `busy = 0`, `done = 0`, `err_range = 0`.
- `start` at edge S: `busy` and `pix_ready` are high from cycle S+1.
- `err_range` pulse: cycle S+1.
- Zero-pixel `done`: cycle S+1.
- Pixel completing a word accepted at edge N: `mem_write` is high in cycle N+1.
- Final pixel accepted at edge L:
  - `mem_write` for the last word is high in cycle L+1.
  - `done` is high in cycle L+2.
  - `busy` is low from cycle L+3.
- Sustained throughput: 1 pixel/cycle, one write every 4 cycles.
- `pix_valid` gaps stall packing only. No timeout.

## Structure
- **Shared package `pixel_writer_pkg`:**
  - `ADDR_W`, `DEPTH`, `CNT_W`, `LANES = 4`.
  - The state enum `{IDLE, PACK, FLUSH, FIN}`.
- **Sub-module `byte_lane_packer`:**
  - Holds the lane counter, pack register and byteenable accumulator.
  - Emits `word`, `be` and `word_valid`.
  - The top level keeps the FSM, the range check, the address counter and the write register.

## Test plan
- **Range reject:** `base_addr = 16380`, `num_pixels = 20` (5 words). Required: `err_range` pulse at S+1, no `mem_write`, `busy` stays 0.
- **Full-rate job:** `base = 0x100`, 8 pixels `0x01..0x08` back-to-back. Required:
  - `0x04030201` at `0x100`, be `0xF`.
  - `0x08070605` at `0x101`.
  - `done` 2 cycles after the last accept.
- **Partial tail:** `base = 0`, 6 pixels `0xA0..0xA5`. Required: second write is `0x0000A5A4` at address 1 with be `0x3`.
- **Zero / overlap:** `num_pixels = 0`. Required: `done` at S+1 and no writes. A `start` pulsed during a busy job is ignored.
- **Gappy valid and abort:** `pix_valid` toggles every other cycle, then `abort` after 3 pixels of the second word. Required: only the first word is written, no `done`, and IDLE is reached next cycle.
- **Reset mid-job:** `reset_n` low for one cycle mid-job. Required: all outputs at reset values next cycle; a new job then runs correctly.
